// File: rtl/bip_datapath_if.sv
// ---------------------------------------------------------------------------
// bip_datapath_if
// Groups the control-unit strobes, the operand field and the datapath status
// outputs of the BIP execution datapath into one bundle.
//
// Signals:
//   operand  instruction[10:0], RAM address or immediate
//   SelA     accumulator source select (00 RAM, 01 imm, 10 ALU, 11 hold)
//   SelB     ALU operand-B select (0 RAM, 1 imm)
//   WrAcc    accumulator write enable
//   Op       ALU operation (0 add, 1 subtract)
//   WrRam    data RAM write enable (stores the accumulator)
//   RdRam    data RAM read enable
//   acc      registered accumulator value
//   flag_z   accumulator-is-zero
//   flag_v   sticky signed-overflow flag
//
// Modports:
//   master   control side: drives strobes/operand, observes status
//   slave    datapath side: consumes strobes/operand, drives status
// ---------------------------------------------------------------------------
interface bip_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] operand;
    logic [1:0]        SelA;
    logic              SelB;
    logic              WrAcc;
    logic              Op;
    logic              WrRam;
    logic              RdRam;
    logic [DATA_W-1:0] acc;
    logic              flag_z;
    logic              flag_v;

    modport master (
        output operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
        input  acc, flag_z, flag_v
    );

    modport slave (
        input  operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
        output acc, flag_z, flag_v
    );
endinterface

// File: rtl/bip_datapath.sv
// ---------------------------------------------------------------------------
// bip_datapath
// Execution datapath of the BIP single-cycle processor. Holds the
// accumulator, the data RAM, the add/sub ALU and the status flags; every
// instruction completes on a single rising clock edge.
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous active-low reset (0 = reset)
//   bus   bip_datapath_if.slave: operand, SelA, SelB, WrAcc, Op, WrRam,
//         RdRam in; acc, flag_z, flag_v out
// ---------------------------------------------------------------------------
module bip_datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          rst,
    bip_datapath_if.slave bus
);

    logic [DATA_W-1:0] ram [DEPTH];

    logic [DATA_W-1:0] acc_q;
    logic              ovf_q;

    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] alu;
    logic              ovf_now;
    logic [DATA_W-1:0] acc_next;
    logic              acc_load;

    // Immediate is the operand field sign-extended to the data width.
    assign imm = {{(DATA_W-ADDR_W){bus.operand[ADDR_W-1]}}, bus.operand};

    // Asynchronous RAM read, forced to zero when the read strobe is off.
    // A store in the same cycle only lands at the edge, so a read of the
    // address being written still sees the old contents here.
    assign mem_rd = bus.RdRam ? ram[bus.operand] : '0;

    assign opnd_b = bus.SelB ? imm : mem_rd;

    // Add/subtract with signed-overflow detection. For subtraction the
    // overflow test uses the inverted sign of B.
    always_comb begin
        alu     = '0;
        ovf_now = 1'b0;
        if (bus.Op) begin
            alu     = acc_q - opnd_b;
            ovf_now = (acc_q[DATA_W-1] != opnd_b[DATA_W-1]) &&
                      (alu[DATA_W-1]   != acc_q[DATA_W-1]);
        end else begin
            alu     = acc_q + opnd_b;
            ovf_now = (acc_q[DATA_W-1] == opnd_b[DATA_W-1]) &&
                      (alu[DATA_W-1]   != acc_q[DATA_W-1]);
        end
    end

    // Accumulator source mux; the reserved SelA=11 code simply holds.
    always_comb begin
        acc_next = acc_q;
        acc_load = 1'b0;
        if (bus.WrAcc) begin
            unique case (bus.SelA)
                2'b00: begin acc_next = mem_rd; acc_load = 1'b1; end
                2'b01: begin acc_next = imm;    acc_load = 1'b1; end
                2'b10: begin acc_next = alu;    acc_load = 1'b1; end
                default: begin acc_next = acc_q; acc_load = 1'b0; end
            endcase
        end
    end

    // Accumulator and sticky overflow flag. Reset wins over any write
    // strobe in the same cycle. The flag only sets on an ALU writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (acc_load) begin
                acc_q <= acc_next;
            end
            if (bus.WrAcc && (bus.SelA == 2'b10) && ovf_now) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Data RAM store of the pre-edge accumulator. Contents survive reset,
    // but writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && bus.WrRam) begin
            ram[bus.operand] <= acc_q;
        end
    end

    assign bus.acc    = acc_q;
    assign bus.flag_z = (acc_q == '0);
    assign bus.flag_v = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// ---------------------------------------------------------------------------
// tb_bip_datapath
// Self-checking bench for bip_datapath. Each instruction is run through a
// behavioural model that pushes the expected acc/flags onto a scoreboard
// queue; after the clock edge the entry is popped and compared to the DUT.
// ---------------------------------------------------------------------------
module tb_bip_datapath;

    typedef struct {
        logic [15:0] acc;
        logic        z;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    bip_datapath_if bus ();

    bip_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t        sb_q [$];
    logic [15:0] m_acc;
    logic        m_v;
    logic [15:0] m_ram [int];

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drives one instruction, models its effect, pushes the expectation,
    // clocks it in and compares the popped expectation with the DUT.
    task automatic applyStimulus(input string tag, input logic rst_v,
                                 input logic [1:0] sel_a, input logic sel_b,
                                 input logic wr_acc, input logic op_v,
                                 input logic wr_ram, input logic rd_ram,
                                 input logic [10:0] opnd);
        logic [15:0] mem_rd;
        logic [15:0] imm;
        logic [15:0] b;
        int          sa;
        int          sb;
        int          res;
        int          si;
        exp_t        e;

        rst         = rst_v;
        bus.SelA    = sel_a;
        bus.SelB    = sel_b;
        bus.WrAcc   = wr_acc;
        bus.Op      = op_v;
        bus.WrRam   = wr_ram;
        bus.RdRam   = rd_ram;
        bus.operand = opnd;

        mem_rd = (rd_ram && m_ram.exists(int'(opnd))) ? m_ram[int'(opnd)] : 16'h0000;
        si     = int'($signed(opnd));
        imm    = 16'(si);
        b      = sel_b ? imm : mem_rd;
        sa     = int'($signed(m_acc));
        sb     = int'($signed(b));
        res    = op_v ? (sa - sb) : (sa + sb);

        if (!rst_v) begin
            m_acc = 16'h0000;
            m_v   = 1'b0;
        end else begin
            if (wr_ram) m_ram[int'(opnd)] = m_acc;
            if (wr_acc) begin
                case (sel_a)
                    2'b00: m_acc = mem_rd;
                    2'b01: m_acc = imm;
                    2'b10: begin
                        m_acc = 16'(res);
                        if (res > 32767 || res < -32768) m_v = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        e.acc = m_acc;
        e.z   = (m_acc == 16'h0000);
        e.v   = m_v;
        sb_q.push_back(e);

        @(posedge clk);
        #1;

        if (sb_q.size() == 0) begin
            checkOutput({tag, ".sb_underflow"}, 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            checkOutput({tag, ".acc"}, bus.acc, e.acc);
            checkOutput({tag, ".z"}, {15'd0, bus.flag_z}, {15'd0, e.z});
            checkOutput({tag, ".v"}, {15'd0, bus.flag_v}, {15'd0, e.v});
        end
    endtask

    // Instruction shorthands on top of applyStimulus.
    task automatic ldi(input string tag, input logic [10:0] v);
        applyStimulus(tag, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v);
    endtask

    task automatic sto(input string tag, input logic [10:0] a);
        applyStimulus(tag, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
    endtask

    task automatic ld(input string tag, input logic [10:0] a);
        applyStimulus(tag, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic addi(input string tag, input logic [10:0] v);
        applyStimulus(tag, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v);
    endtask

    task automatic addm(input string tag, input logic [10:0] a);
        applyStimulus(tag, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic subm(input string tag, input logic [10:0] a);
        applyStimulus(tag, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a);
    endtask

    task automatic dbl(input string tag, input logic [10:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            sto({tag, ".sto"}, a);
            addm({tag, ".add"}, a);
        end
    endtask

    // Main sequence: reset behaviour, load/store, ALU, overflow, combined
    // store+load, read gating and same-address read/write.
    initial begin
        m_acc = 16'h0000;
        m_v   = 1'b0;

        applyStimulus("por0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        applyStimulus("por1", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);

        ldi("ldi_aa", 11'h0AA);
        sto("sto5", 11'd5);
        ldi("ldi_77", 11'h077);
        applyStimulus("rst_a", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd5);
        applyStimulus("rst_b", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd5);
        ld("ld5_kept", 11'd5);

        ldi("ldi_3ff", 11'h3FF);
        sto("sto7", 11'd7);
        ldi("ldi_400", 11'h400);
        ld("ld7", 11'd7);

        ldi("ldi_10", 11'h010);
        addi("addi5", 11'd5);
        sto("sto7b", 11'd7);
        subm("sub_zero", 11'd7);

        ldi("ldi_fc00", 11'h400);
        dbl("dbl8000", 11'd30, 5);
        sto("sto20", 11'd20);
        ldi("ldi_ffff", 11'h7FF);
        subm("sub_7fff", 11'd20);
        addi("addi_ovf", 11'd1);
        ldi("ldi0_sticky", 11'd0);
        applyStimulus("rst_v", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);

        ldi("ldi_123", 11'h123);
        dbl("dbl1230", 11'd31, 4);
        addi("addi4", 11'd4);
        applyStimulus("sto_ldi9", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd9);
        ld("ld9", 11'd9);

        ldi("ldi_17d", 11'h17D);
        dbl("dblbe80", 11'd32, 7);
        addi("addi_6f", 11'h06F);
        sto("sto3", 11'd3);
        ldi("ldi5", 11'd5);
        applyStimulus("rd_gated", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd3);
        ldi("ldi7", 11'd7);
        applyStimulus("sela11", 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h055);
        applyStimulus("wracc0", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h055);
        applyStimulus("rw_same", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd3);
        ld("ld3_new", 11'd3);

        checkOutput("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
